// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory-interface types: word type, RAM handshake states and
// the width of the RAM latency counter.
package cpu_types_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned RAM_LAT_W = 4;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

endpackage

// File: rtl/ram_array.sv
// Word-addressed storage: synchronous write, asynchronous read, no reset.
module ram_array
  import cpu_types_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 10
) (
  input  logic                 i_clk,
  input  logic                 i_we,
  input  logic [ADDR_BITS-1:0] i_waddr,
  input  word_t                i_wdata,
  input  logic [ADDR_BITS-1:0] i_raddr,
  output word_t                o_rdata
);

  word_t r_mem [2**ADDR_BITS];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ram_responder.sv
// Memory-side responder: answers ramREN/ramWEN requests with a fixed
// BUSY latency, then one ACCESS cycle in which the word is read or written.
module ram_responder
  import cpu_types_pkg::*;
#(
  parameter int unsigned LAT       = 2,
  parameter int unsigned ADDR_BITS = 10
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      ramREN,
  input  logic      ramWEN,
  input  word_t     ramaddr,
  input  word_t     ramstore,
  output word_t     ramload,
  output ramstate_t ramstate
);

  localparam logic [RAM_LAT_W-1:0] CNT_INIT = RAM_LAT_W'(LAT - 1);
  localparam logic [RAM_LAT_W-1:0] CNT_ONE  = RAM_LAT_W'(1);

  ramstate_t            r_state;
  word_t                r_load;
  logic [RAM_LAT_W-1:0] r_cnt;
  logic                 r_wen;
  word_t                r_addr;
  word_t                r_store;

  logic                 w_req;
  logic                 w_bad;
  logic                 w_same;
  logic                 w_we;
  logic [ADDR_BITS-1:0] w_idx;
  word_t                w_rdata;

  assign w_req  = ramREN ^ ramWEN;
  assign w_bad  = (ramREN & ramWEN) | (w_req & (ramaddr[1:0] != 2'b00));
  assign w_same = (r_wen == ramWEN) && (r_addr == ramaddr) && (r_store == ramstore);
  assign w_idx  = ramaddr[ADDR_BITS+1:2];
  // The write lands on the same edge that moves BUSY to ACCESS.
  assign w_we   = (r_state == BUSY) && w_req && !w_bad && w_same
                  && (r_cnt == '0) && r_wen;

  ram_array #(
    .ADDR_BITS(ADDR_BITS)
  ) u_ram_array (
    .i_clk  (CLK),
    .i_we   (w_we),
    .i_waddr(w_idx),
    .i_wdata(r_store),
    .i_raddr(w_idx),
    .o_rdata(w_rdata)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= FREE;
      r_load  <= '0;
      r_cnt   <= '0;
      r_wen   <= 1'b0;
      r_addr  <= '0;
      r_store <= '0;
    end else if (w_bad) begin
      r_state <= ERROR;
    end else begin
      case (r_state)
        BUSY: begin
          if (!w_req) begin
            r_state <= FREE;
          end else if (!w_same) begin
            r_state <= BUSY;
            r_wen   <= ramWEN;
            r_addr  <= ramaddr;
            r_store <= ramstore;
            r_cnt   <= CNT_INIT;
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_ONE;
          end else begin
            r_state <= ACCESS;
            if (!r_wen) r_load <= w_rdata;
          end
        end
        default: begin
          if (w_req) begin
            r_state <= BUSY;
            r_wen   <= ramWEN;
            r_addr  <= ramaddr;
            r_store <= ramstore;
            r_cnt   <= CNT_INIT;
          end else begin
            r_state <= FREE;
          end
        end
      endcase
    end
  end

  assign ramstate = r_state;
  assign ramload  = r_load;

endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder with a transaction-level reference model
// checked every cycle, plus literal expectations on the directed sequence.
module tb_ram_responder;
  import cpu_types_pkg::*;

  localparam int unsigned LAT = 2;
  localparam int unsigned AB  = 10;

  logic      CLK;
  logic      nRST;
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  ram_responder #(
    .LAT      (LAT),
    .ADDR_BITS(AB)
  ) dut (
    .CLK     (CLK),
    .nRST    (nRST),
    .ramREN  (ramREN),
    .ramWEN  (ramWEN),
    .ramaddr (ramaddr),
    .ramstore(ramstore),
    .ramload (ramload),
    .ramstate(ramstate)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a request becomes ACCESS once the same good request has
  // been seen on LAT+1 consecutive edges starting from a non-BUSY state.
  word_t       m_mem [int];
  ramstate_t   m_st = FREE;
  word_t       m_load = '0;
  bit          m_load_ok = 1'b1;
  int unsigned m_run = 0;
  logic [65:0] m_prev = '0;

  initial begin
    forever begin
      @(posedge CLK);
      if (!nRST) begin
        m_st = FREE; m_load = '0; m_load_ok = 1'b1; m_run = 0; m_prev = '0;
      end else begin
        logic        r, w, bad;
        logic [65:0] cur;
        int          idx;
        r   = ramREN;
        w   = ramWEN;
        cur = {r, w, ramaddr, ramstore};
        idx = int'(ramaddr[AB+1:2]);
        bad = (r & w) | ((r ^ w) & (ramaddr[1:0] != 2'b00));
        if (bad) begin
          m_st = ERROR; m_run = 0;
        end else if (!(r ^ w)) begin
          m_st = FREE; m_run = 0;
        end else if (m_st != BUSY || cur != m_prev) begin
          m_st = BUSY; m_run = 1;
        end else begin
          m_run++;
          if (m_run == LAT + 1) begin
            m_st = ACCESS;
            if (w) m_mem[idx] = ramstore;
            else if (m_mem.exists(idx)) begin m_load = m_mem[idx]; m_load_ok = 1'b1; end
            else m_load_ok = 1'b0;
          end
        end
        m_prev = cur;
      end
      #2;
      chk("model_state", 32'(ramstate), 32'(m_st));
      if (m_load_ok) chk("model_load", ramload, m_load);
    end
  end

  task automatic req(input logic r, input logic w, input word_t a, input word_t s);
    ramREN = r; ramWEN = w; ramaddr = a; ramstore = s;
  endtask

  task automatic tick(input string nm, input ramstate_t exp);
    @(negedge CLK);
    chk(nm, 32'(ramstate), 32'(exp));
  endtask

  task automatic do_write(input word_t a, input word_t d);
    req(1'b0, 1'b1, a, d);
    tick("wr_busy1", BUSY); tick("wr_busy2", BUSY); tick("wr_access", ACCESS);
    req(1'b0, 1'b0, '0, '0);
    tick("wr_free", FREE);
  endtask

  task automatic do_read(input word_t a, input word_t exp);
    req(1'b1, 1'b0, a, '0);
    tick("rd_busy1", BUSY); tick("rd_busy2", BUSY); tick("rd_access", ACCESS);
    chk("rd_data", ramload, exp);
    req(1'b0, 1'b0, '0, '0);
    tick("rd_free", FREE);
  endtask

  initial begin
    nRST = 1'b0;
    req(1'b0, 1'b0, '0, '0);
    repeat (2) @(negedge CLK);
    chk("reset_state", 32'(ramstate), 32'(FREE));
    chk("reset_load", ramload, 32'h0);
    nRST = 1'b1;

    // write then read back
    do_write(32'h0000_0040, 32'hDEAD_BEEF);
    do_read(32'h0000_0040, 32'hDEAD_BEEF);

    // abort after one BUSY cycle leaves old contents
    do_write(32'h0000_0080, 32'hCAFE_F00D);
    req(1'b0, 1'b1, 32'h0000_0080, 32'h0000_1234);
    tick("abort_busy", BUSY);
    req(1'b0, 1'b0, '0, '0);
    tick("abort_free", FREE);
    do_read(32'h0000_0080, 32'hCAFE_F00D);

    // asynchronous reset mid-BUSY drops the pending write
    req(1'b0, 1'b1, 32'h0000_0080, 32'h5555_5555);
    tick("rst_busy", BUSY);
    #2 nRST = 1'b0;
    req(1'b0, 1'b0, '0, '0);
    #1;
    chk("async_rst_state", 32'(ramstate), 32'(FREE));
    chk("async_rst_load", ramload, 32'h0);
    @(negedge CLK);
    nRST = 1'b1;
    do_read(32'h0000_0080, 32'hCAFE_F00D);

    // restart: address changes in the second BUSY cycle
    do_write(32'h0000_0010, 32'h1111_1111);
    do_write(32'h0000_0014, 32'h2222_2222);
    req(1'b1, 1'b0, 32'h0000_0010, '0);
    tick("rs_busy1", BUSY); tick("rs_busy2", BUSY);
    req(1'b1, 1'b0, 32'h0000_0014, '0);
    tick("rs_busy3", BUSY); tick("rs_busy4", BUSY); tick("rs_access", ACCESS);
    chk("rs_data", ramload, 32'h2222_2222);
    req(1'b0, 1'b0, '0, '0);
    tick("rs_free", FREE);

    // errors: both enables, then misaligned then corrected address
    req(1'b1, 1'b1, 32'h0000_0040, 32'h0BAD_0BAD);
    tick("err_both1", ERROR); tick("err_both2", ERROR);
    req(1'b1, 1'b0, 32'h0000_0003, '0);
    tick("err_align", ERROR);
    req(1'b1, 1'b0, 32'h0000_0004, '0);
    tick("err_fix_busy", BUSY);
    req(1'b0, 1'b0, '0, '0);
    tick("err_free", FREE);
    req(1'b0, 1'b1, 32'h0000_0042, 32'h0BAD_0BAD);
    tick("err_wr_align", ERROR);
    req(1'b0, 1'b0, '0, '0);
    tick("err_to_free", FREE);
    do_read(32'h0000_0040, 32'hDEAD_BEEF);

    // aliasing and back-to-back reads held across ACCESS
    do_write(32'h1000_0008, 32'hA5A5_5A5A);
    do_write(32'h0000_0FFC, 32'h7777_0001);
    req(1'b1, 1'b0, 32'h0000_0008, '0);
    tick("b2b_busy1", BUSY); tick("b2b_busy2", BUSY); tick("b2b_access1", ACCESS);
    chk("alias_data", ramload, 32'hA5A5_5A5A);
    tick("b2b_busy3", BUSY);
    chk("b2b_load_hold", ramload, 32'hA5A5_5A5A);
    req(1'b1, 1'b0, 32'hF000_0FFC, '0);
    tick("b2b_busy4", BUSY); tick("b2b_busy5", BUSY); tick("b2b_access2", ACCESS);
    chk("top_word_data", ramload, 32'h7777_0001);
    req(1'b0, 1'b0, '0, '0);
    tick("end_free", FREE);

    repeat (3) @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
